shift_ram_multitap: RTL and testbench
=====================================

SHIFT_RAM_MULTITAP -- requirements
Module: shift_ram_multitap

Interface
REQ-001: Parameter DATA_WIDTH, default 8, is the sample width in bits (1..64).
REQ-002: Parameter DEPTH, default 1024, is the maximum line length in samples (power of two, 16..4096).
REQ-003: Parameter TAPS, default 3, is the number of cascaded line delays (1..8).
REQ-004: Port clk, input, 1, is the single clock; all logic is rising-edge.
REQ-005: Port reset, input, 1, is the synchronous active-high reset.
REQ-006: Port clear, input, 1, is a synchronous flush; it restarts fill and latches line_len.
REQ-007: Port line_len, input, $clog2(DEPTH+1), is the runtime line length; it is sampled only on reset or clear.
REQ-008: Port in_valid, input, 1, is the sample strobe; a shift occurs only when it is high.
REQ-009: Port in_data, input, DATA_WIDTH, is the incoming sample.
REQ-010: Port out_valid, output, 1, is in_valid delayed by the block latency.
REQ-011: Port out_cur, output, DATA_WIDTH, is in_data aligned with the taps.
REQ-012: Port out_taps, output, TAPS*DATA_WIDTH; slice k is the sample delayed (k+1)*L accepted beats.
REQ-013: Port taps_full, output, 1, is high once TAPS*L beats have been accepted since the last reset or clear.

Function
REQ-014: L SHALL be the latched line_len; a value of 0 or greater than DEPTH SHALL be treated as DEPTH.
REQ-015: One shared write/read pointer SHALL advance on each in_valid beat and wrap from L-1 to 0.
REQ-016: Each tap RAM SHALL be read-first: on an in_valid beat at pointer p, it outputs the old word at p and stores the new word at p.
REQ-017: Tap 0 SHALL store in_data; tap k SHALL store tap k-1's read data, giving a cascaded line delay.
REQ-018: Base latency from in_valid to out_valid SHALL be 1 cycle.
REQ-019: When in_valid is low, the pointer, RAM contents and outputs SHALL hold, and out_valid SHALL be 0.
REQ-020: The fill counter SHALL saturate at TAPS*L and taps_full SHALL be high while it is saturated.
REQ-021: Before taps_full, tap data SHALL be stale or zero, but out_valid still SHALL follow in_valid.
REQ-022: On clear, the pointer and fill counter SHALL be zeroed, L SHALL be relatched, and any in_valid in the same cycle SHALL be ignored.
REQ-023: A line_len change without clear SHALL have no effect.

Reset
REQ-024: On reset, out_valid, taps_full, out_cur, out_taps, the pointer and the fill counter SHALL be 0 and L SHALL be latched.
REQ-025: RAM contents SHALL NOT be reset; reset asserted mid-stream SHALL take priority over in_valid and clear.

Configuration
REQ-026: With SHIFT_RAM_OUTREG_EN defined, an additional output register stage SHALL be added, latency becomes 2, and the stage is reset to 0.
REQ-027: Without SHIFT_RAM_OUTREG_EN, latency SHALL be 1.

Structure
REQ-028: Package shift_ram_pkg SHALL hold the DEPTH/TAPS limits, the pointer-width function and the latency constant.
REQ-029: Sub-module sdp_ram_rf (single-clock, read-first simple dual-port RAM, one instance per tap) SHALL be used.

Verification
REQ-030: DATA_WIDTH=8, DEPTH=16, TAPS=2, line_len=4, in_data=1,2,3,... every cycle -> at beat 9, out_cur=9, tap0=5, tap1=1, and taps_full rises with that beat.
REQ-031: Same configuration with in_valid high every other cycle -> identical tap values per accepted beat, and out_valid toggles in step.
REQ-032: line_len=0 -> L=16; tap0 equals the input from 16 beats earlier.
REQ-033: clear asserted at beat 6 with line_len=3 and in_valid high -> that beat is dropped, taps_full is 0, and taps_full rises after 6 further beats.
REQ-034: Reset asserted at beat 5 while in_valid is high -> out_valid=0 and taps_full=0 next cycle, and the pointer restarts at 0.
REQ-035: SHIFT_RAM_OUTREG_EN defined -> every response in REQ-030 is delayed by exactly one extra cycle.

Source files
------------

// File: rtl/shift_ram_multitap_pkg.sv
// ---------------------------------------------------------------------------
// shift_ram_pkg
//   Shared constants and helpers for the shift_ram_multitap line-delay block.
//   - Parameter limits for DEPTH, TAPS and DATA_WIDTH.
//   - ptr_width(): width of the shared RAM pointer for a given DEPTH.
//   - LATENCY: in_valid -> out_valid latency in cycles. The value depends on
//     the SHIFT_RAM_OUTREG_EN macro, which adds an output register stage.
// ---------------------------------------------------------------------------
package shift_ram_pkg;

    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 64;
    localparam int DEPTH_MIN      = 16;
    localparam int DEPTH_MAX      = 4096;
    localparam int TAPS_MIN       = 1;
    localparam int TAPS_MAX       = 8;

    // Latency of the core (RAM read plus one output register).
    localparam int BASE_LATENCY   = 1;

`ifdef SHIFT_RAM_OUTREG_EN
    localparam int LATENCY = BASE_LATENCY + 1;
`else
    localparam int LATENCY = BASE_LATENCY;
`endif

    // Number of address bits needed to index 'depth' words (at least 1).
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/shift_ram_multitap_sdp_ram_rf.sv
// ---------------------------------------------------------------------------
// sdp_ram_rf
//   Single-clock simple dual-port RAM with read-first behaviour.
//   The read port is combinational, so in a cycle where the write port
//   targets the same address the read port still returns the old word; the
//   new word becomes visible from the next cycle. The storage has no reset.
//
//   Ports:
//     clk    in   rising-edge clock
//     we     in   write enable
//     waddr  in   write address   [AW-1:0]
//     wdata  in   write data      [DATA_WIDTH-1:0]
//     raddr  in   read address    [AW-1:0]
//     rdata  out  read data       [DATA_WIDTH-1:0] (old contents at raddr)
// ---------------------------------------------------------------------------
module sdp_ram_rf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: store the incoming word on an enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/shift_ram_multitap.sv
// ---------------------------------------------------------------------------
// shift_ram_multitap
//   Cascaded line-delay block. TAPS read-first RAMs share one pointer that
//   advances on every accepted sample and wraps at the latched line length
//   L. Tap 0 stores the input sample, tap k stores what tap k-1 just read,
//   so tap k presents the sample accepted (k+1)*L beats earlier.
//
//   Optional build macro:
//     SHIFT_RAM_OUTREG_EN  adds one output register stage (latency 2).
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset; latches line_len
//     clear      in   synchronous flush; restarts fill, latches line_len,
//                     drops any in_valid of the same cycle
//     line_len   in   runtime line length (0 or > DEPTH means DEPTH)
//     in_valid   in   sample strobe; RAMs and pointer move only when high
//     in_data    in   incoming sample
//     out_valid  out  in_valid delayed by the block latency
//     out_cur    out  in_data aligned with the taps
//     out_taps   out  slice k = sample delayed (k+1)*L accepted beats
//     taps_full  out  high on outputs whose every tap holds stream data
// ---------------------------------------------------------------------------
module shift_ram_multitap
    import shift_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int TAPS       = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [$clog2(DEPTH+1)-1:0] line_len,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_cur,
    output logic [TAPS*DATA_WIDTH-1:0] out_taps,
    output logic                       taps_full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(TAPS * DEPTH + 1);

    // Elaboration-time parameter range guard.
    if ((DEPTH < DEPTH_MIN) || (DEPTH > DEPTH_MAX) ||
        (TAPS < TAPS_MIN) || (TAPS > TAPS_MAX) ||
        (DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX)) begin : g_param_err
        $error("shift_ram_multitap: parameter out of range");
    end

    logic [LW-1:0]              len_r;
    logic [LW-1:0]              len_eff_s;
    logic [PW-1:0]              ptr_r;
    logic [PW-1:0]              ptr_next_s;
    logic [FW-1:0]              fill_r;
    logic [FW-1:0]              fill_max_s;
    logic [FW-1:0]              fill_next_s;
    logic                       beat_s;

    logic [DATA_WIDTH-1:0]      tap_wr_s [TAPS];
    logic [DATA_WIDTH-1:0]      tap_rd_s [TAPS];

    logic                       valid1_r;
    logic                       full1_r;
    logic [DATA_WIDTH-1:0]      cur1_r;
    logic [TAPS*DATA_WIDTH-1:0] taps1_r;

    // Effective line length, pointer wrap, fill saturation and write enable.
    always_comb begin
        len_eff_s   = line_len;
        ptr_next_s  = ptr_r;
        fill_next_s = fill_r;
        fill_max_s  = FW'(TAPS) * FW'(len_r);
        beat_s      = in_valid & ~reset & ~clear;

        if ((line_len == {LW{1'b0}}) || (line_len > LW'(DEPTH))) begin
            len_eff_s = LW'(DEPTH);
        end else begin
            len_eff_s = line_len;
        end

        if (LW'(ptr_r) == (len_r - LW'(1))) begin
            ptr_next_s = {PW{1'b0}};
        end else begin
            ptr_next_s = ptr_r + PW'(1);
        end

        if (fill_r == fill_max_s) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + FW'(1);
        end
    end

    // One RAM per tap; each tap is fed by the previous tap's read data.
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_first
            assign tap_wr_s[k] = in_data;
        end else begin : g_next
            assign tap_wr_s[k] = tap_rd_s[k-1];
        end

        sdp_ram_rf #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AW         (PW)
        ) u_ram (
            .clk   (clk),
            .we    (beat_s),
            .waddr (ptr_r),
            .wdata (tap_wr_s[k]),
            .raddr (ptr_r),
            .rdata (tap_rd_s[k])
        );
    end

    // Control state and the first output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r    <= len_eff_s;
            ptr_r    <= {PW{1'b0}};
            fill_r   <= {FW{1'b0}};
            valid1_r <= 1'b0;
            full1_r  <= 1'b0;
            cur1_r   <= {DATA_WIDTH{1'b0}};
            taps1_r  <= {(TAPS*DATA_WIDTH){1'b0}};
        end else if (clear) begin
            len_r    <= len_eff_s;
            ptr_r    <= {PW{1'b0}};
            fill_r   <= {FW{1'b0}};
            valid1_r <= 1'b0;
            full1_r  <= 1'b0;
        end else if (in_valid) begin
            ptr_r    <= ptr_next_s;
            fill_r   <= fill_next_s;
            valid1_r <= 1'b1;
            // The pre-beat count tells whether the data read on this beat
            // has travelled through every tap since the last restart.
            full1_r  <= (fill_r == fill_max_s);
            cur1_r   <= in_data;
            for (int k = 0; k < TAPS; k++) begin
                taps1_r[k*DATA_WIDTH +: DATA_WIDTH] <= tap_rd_s[k];
            end
        end else begin
            valid1_r <= 1'b0;
        end
    end

`ifdef SHIFT_RAM_OUTREG_EN
    logic                       valid2_r;
    logic                       full2_r;
    logic [DATA_WIDTH-1:0]      cur2_r;
    logic [TAPS*DATA_WIDTH-1:0] taps2_r;

    // Optional extra output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid2_r <= 1'b0;
            full2_r  <= 1'b0;
            cur2_r   <= {DATA_WIDTH{1'b0}};
            taps2_r  <= {(TAPS*DATA_WIDTH){1'b0}};
        end else begin
            valid2_r <= valid1_r;
            full2_r  <= full1_r;
            cur2_r   <= cur1_r;
            taps2_r  <= taps1_r;
        end
    end

    assign out_valid = valid2_r;
    assign taps_full = full2_r;
    assign out_cur   = cur2_r;
    assign out_taps  = taps2_r;
`else
    assign out_valid = valid1_r;
    assign taps_full = full1_r;
    assign out_cur   = cur1_r;
    assign out_taps  = taps1_r;
`endif

endmodule

// File: tb/tb_shift_ram_multitap.sv
// ---------------------------------------------------------------------------
// tb_shift_ram_multitap
//   Self-checking bench for shift_ram_multitap (DATA_WIDTH=8, DEPTH=16,
//   TAPS=2). A queue of accepted samples predicts every output; a few
//   literal values pin the predictions for known sequences.
// ---------------------------------------------------------------------------
module tb_shift_ram_multitap;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int TAPS  = 2;
`ifdef SHIFT_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              reset;
    logic              clear;
    logic [4:0]        line_len;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic [DW-1:0]     out_cur;
    logic [TAPS*DW-1:0] out_taps;
    logic              taps_full;

    shift_ram_multitap #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TAPS       (TAPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .line_len  (line_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_cur   (out_cur),
        .out_taps  (out_taps),
        .taps_full (taps_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic               valid;
        logic               full;
        logic [DW-1:0]      cur;
        logic [TAPS*DW-1:0] taps;
        logic               chk_valid;
        logic               chk_full;
        logic               chk_zero;
        logic               chk_taps;
    } exp_t;

    exp_t          pipe [LAT];
    int            hist [$];
    int            beats_m;
    int            len_m;
    int            n_tests;
    int            n_fail;
    int            pin_phase;
    int            pin_beat;

    function automatic int eff_len(input logic [4:0] v);
        if ((v == 5'd0) || (int'(v) > DEPTH)) return DEPTH;
        return int'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one step per rising edge using the sampled inputs.
    task automatic model_step();
        exp_t rec;
        rec = '0;
        if (reset) begin
            len_m   = eff_len(line_len);
            hist.delete();
            beats_m = 0;
            rec.chk_valid = 1'b1;
            rec.chk_full  = 1'b1;
            rec.chk_zero  = 1'b1;
            for (int i = 0; i < LAT; i++) pipe[i] = rec;
        end else begin
            if (clear) begin
                len_m   = eff_len(line_len);
                hist.delete();
                beats_m = 0;
                rec.chk_valid = 1'b1;
                rec.chk_full  = 1'b1;
            end else if (in_valid) begin
                rec.chk_valid = 1'b1;
                rec.chk_full  = 1'b1;
                rec.valid     = 1'b1;
                rec.cur       = in_data;
                rec.full      = (beats_m >= TAPS * len_m);
                hist.push_back(int'(in_data));
                beats_m++;
                if (rec.full) begin
                    rec.chk_taps = 1'b1;
                    for (int k = 0; k < TAPS; k++)
                        rec.taps[k*DW +: DW] = DW'(hist[hist.size() - 1 - (k + 1) * len_m]);
                end
                if (hist.size() > 64) void'(hist.pop_front());
            end else begin
                rec.chk_valid = 1'b1;
            end
            for (int i = 0; i < LAT - 1; i++) pipe[i] = pipe[i + 1];
            pipe[LAT - 1] = rec;
        end
    endtask

    initial begin
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Literal expectations for the directed sequences.
    task automatic pin_check();
        logic [DW-1:0] t0, t1;
        t0 = out_taps[DW-1:0];
        t1 = out_taps[2*DW-1:DW];
        case (pin_phase)
            1, 2: begin
                if (pin_beat == 8) check("pin_full_b8", 32'(taps_full), 32'd0);
                if (pin_beat == 9) begin
                    check("pin_cur_b9",  32'(out_cur), 32'd9);
                    check("pin_tap0_b9", 32'(t0), 32'd5);
                    check("pin_tap1_b9", 32'(t1), 32'd1);
                    check("pin_full_b9", 32'(taps_full), 32'd1);
                end
            end
            3: begin
                if (pin_beat == 32) check("pin_full_l16_b32", 32'(taps_full), 32'd0);
                if (pin_beat == 33) check("pin_full_l16_b33", 32'(taps_full), 32'd1);
                if (pin_beat == 40) begin
                    check("pin_cur_l16",  32'(out_cur), 32'd40);
                    check("pin_tap0_l16", 32'(t0), 32'd24);
                    check("pin_tap1_l16", 32'(t1), 32'd8);
                end
            end
            4: begin
                if (pin_beat == 11) check("pin_full_clr_b6", 32'(taps_full), 32'd0);
                if (pin_beat == 12) begin
                    check("pin_full_clr_b7", 32'(taps_full), 32'd1);
                    check("pin_cur_clr",  32'(out_cur), 32'd13);
                    check("pin_tap0_clr", 32'(t0), 32'd10);
                    check("pin_tap1_clr", 32'(t1), 32'd7);
                end
            end
            5: begin
                if (pin_beat == 12) check("pin_full_rst_b8", 32'(taps_full), 32'd0);
                if (pin_beat == 13) begin
                    check("pin_full_rst_b9", 32'(taps_full), 32'd1);
                    check("pin_cur_rst",  32'(out_cur), 32'd14);
                    check("pin_tap0_rst", 32'(t0), 32'd10);
                    check("pin_tap1_rst", 32'(t1), 32'd6);
                end
            end
            default: ;
        endcase
    endtask

    // Compare process: checks DUT outputs against the model on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            e = pipe[0];
            if (e.chk_valid) check("out_valid", 32'(out_valid), 32'(e.valid));
            if (e.chk_full)  check("taps_full", 32'(taps_full), 32'(e.full));
            if (e.chk_zero) begin
                check("out_cur_reset",  32'(out_cur),  32'd0);
                check("out_taps_reset", 32'(out_taps), 32'd0);
            end
            if (e.valid) begin
                check("out_cur", 32'(out_cur), 32'(e.cur));
                if (e.chk_taps) check("out_taps", 32'(out_taps), 32'(e.taps));
                pin_beat++;
                pin_check();
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [DW-1:0] d, input logic [4:0] ll);
        reset    = r;
        clear    = c;
        in_valid = v;
        in_data  = d;
        line_len = ll;
        @(posedge clk);
        #1;
    endtask

    task automatic start_phase(input int ph, input logic [4:0] ll);
        step(1'b1, 1'b0, 1'b0, 8'd0, ll);
        step(1'b1, 1'b0, 1'b0, 8'd0, ll);
        pin_phase = ph;
        pin_beat  = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, line_len);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        pin_phase = 0;
        pin_beat  = 0;
        beats_m   = 0;
        len_m     = DEPTH;

        // Continuous stream, L = 4.
        start_phase(1, 5'd4);
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 5'd4);
        idle(3);

        // Every other cycle, L = 4.
        start_phase(2, 5'd4);
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 1'b1, DW'(i), 5'd4);
            step(1'b0, 1'b0, 1'b0, 8'd0, 5'd4);
        end
        idle(3);

        // line_len = 0 selects the full depth.
        start_phase(3, 5'd0);
        for (int i = 1; i <= 42; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 5'd0);
        idle(3);

        // Clear on beat 6 with a new length of 3; that beat is dropped.
        start_phase(4, 5'd4);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 5'd4);
        step(1'b0, 1'b1, 1'b1, 8'd6, 5'd3);
        for (int i = 7; i <= 15; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 5'd9);
        idle(3);

        // Reset on beat 5 while in_valid is high.
        start_phase(5, 5'd4);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 5'd4);
        step(1'b1, 1'b0, 1'b1, 8'd5, 5'd4);
        for (int i = 6; i <= 16; i++) step(1'b0, 1'b0, 1'b1, DW'(i), 5'd4);
        idle(3);

        // Randomized traffic with length changes, clears and resets.
        pin_phase = 0;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 7),
                 DW'($urandom),
                 5'($urandom_range(0, 20)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
